// File: rtl/norefpot_rom_uart_streamer.sv
// Self-running sample source: a ramp ROM is stepped at a fixed sample rate and each
// byte is sent on an 8N1 UART line, LSB first.
module norefpot_rom_uart_streamer #(
    parameter int unsigned BAUD_DIV   = 434,
    parameter int unsigned SAMPLE_DIV = 5000,
    parameter int unsigned ADDR_W     = 8
) (
    input  logic clk,
    input  logic rst,
    output logic TxD,
    output logic TxD_busy,
    output logic ena2
);

    localparam int unsigned SampW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned BaudW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    typedef logic [SampW-1:0]  samp_t;
    typedef logic [BaudW-1:0]  baud_t;
    typedef logic [ADDR_W-1:0] addr_t;

    localparam samp_t SampLast = samp_t'(SAMPLE_DIV - 1);
    localparam baud_t BaudLast = baud_t'(BAUD_DIV - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e     state_q, state_d;
    samp_t      samp_cnt_q, samp_cnt_d;
    baud_t      baud_cnt_q, baud_cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    addr_t      addr_q, addr_d;
    logic       pending_q, pending_d;
    logic       tx_q, tx_d;
    logic       busy_q, busy_d;

    logic [7:0] rom_byte;
    logic       baud_done;
    logic       frame_done;
    logic       tx_free;
    logic       launch;

    // Ramp ROM: each entry is the low byte of its own address.
    assign rom_byte = 8'(addr_q);

    assign ena2       = (samp_cnt_q == SampLast);
    assign baud_done  = (baud_cnt_q == BaudLast);
    assign frame_done = (state_q == StStop) && baud_done;
    // The edge that ends the stop bit can also start the next frame.
    assign tx_free    = (state_q == StIdle) || frame_done;
    assign launch     = (ena2 || pending_q) && tx_free;

    assign TxD      = tx_q;
    assign TxD_busy = busy_q;

    always_comb begin
        state_d    = state_q;
        samp_cnt_d = ena2 ? samp_t'(0) : samp_cnt_q + samp_t'(1);
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        addr_d     = addr_q;
        pending_d  = pending_q;
        tx_d       = tx_q;
        busy_d     = busy_q;

        if (state_q != StIdle) begin
            baud_cnt_d = baud_done ? baud_t'(0) : baud_cnt_q + baud_t'(1);
        end

        case (state_q)
            StIdle: ;
            StStart: begin
                if (baud_done) begin
                    state_d   = StData;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                end
            end
            StData: begin
                if (baud_done) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            StStop: begin
                if (baud_done) begin
                    state_d = StIdle;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (launch) begin
            state_d    = StStart;
            baud_cnt_d = baud_t'(0);
            shift_d    = rom_byte;
            addr_d     = addr_q + addr_t'(1);
            pending_d  = 1'b0;
            tx_d       = 1'b0;
            busy_d     = 1'b1;
        end else if (ena2 && !tx_free) begin
            // Only one request is remembered; extra ticks while pending are lost.
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            samp_cnt_q <= samp_t'(0);
            baud_cnt_q <= baud_t'(0);
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'd0;
            addr_q     <= addr_t'(0);
            pending_q  <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            samp_cnt_q <= samp_cnt_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            addr_q     <= addr_d;
            pending_q  <= pending_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: tb/tb_norefpot_rom_uart_streamer.sv
// Bench for the ROM UART streamer: two instances (slow ticks / overrun with a 4-entry ROM)
// compared cycle by cycle against a frame-level reference model, plus UART decoding.
module tb_norefpot_rom_uart_streamer;

    localparam int BD   = 4;
    localparam int MAXC = 1024;

    logic clk;
    logic rst;
    logic tx_a, busy_a, ena_a;
    logic tx_b, busy_b, ena_b;

    int checks = 0;
    int errors = 0;

    norefpot_rom_uart_streamer #(
        .BAUD_DIV  (4),
        .SAMPLE_DIV(64),
        .ADDR_W    (8)
    ) u_dut_a (
        .clk     (clk),
        .rst     (rst),
        .TxD     (tx_a),
        .TxD_busy(busy_a),
        .ena2    (ena_a)
    );

    norefpot_rom_uart_streamer #(
        .BAUD_DIV  (4),
        .SAMPLE_DIV(16),
        .ADDR_W    (2)
    ) u_dut_b (
        .clk     (clk),
        .rst     (rst),
        .TxD     (tx_b),
        .TxD_busy(busy_b),
        .ena2    (ena_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: edges since release, last launch edge, byte in flight, request flag.
    int m_cyc  [2];
    int m_l    [2];
    int m_byte [2];
    int m_addr [2];
    bit m_act  [2];
    bit m_pend [2];

    function automatic int sd_of(input int i);
        return (i == 0) ? 64 : 16;
    endfunction

    function automatic int depth_of(input int i);
        return (i == 0) ? 256 : 4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cyc[i] = 0; m_l[i] = 0; m_byte[i] = 0;
            m_addr[i] = 0; m_act[i] = 1'b0; m_pend[i] = 1'b0;
        end
    endtask

    task automatic model_step(input int i);
        int e;
        bit tick, avail;
        e     = m_cyc[i] + 1;
        tick  = (m_cyc[i] % sd_of(i)) == sd_of(i) - 1;
        avail = !m_act[i] || (e >= m_l[i] + 10 * BD);
        if (avail && (tick || m_pend[i])) begin
            m_l[i]    = e;
            m_act[i]  = 1'b1;
            m_byte[i] = m_addr[i] % 256;
            m_addr[i] = (m_addr[i] + 1) % depth_of(i);
            m_pend[i] = 1'b0;
        end else if (tick && !avail) begin
            m_pend[i] = 1'b1;
        end
        m_cyc[i] = e;
    endtask

    function automatic bit exp_ena(input int i);
        return rst && ((m_cyc[i] % sd_of(i)) == sd_of(i) - 1);
    endfunction

    function automatic bit exp_busy(input int i);
        return rst && m_act[i] && ((m_cyc[i] - m_l[i]) < 10 * BD);
    endfunction

    function automatic bit exp_tx(input int i);
        int bn;
        logic [7:0] b;
        if (!exp_busy(i)) return 1'b1;
        bn = (m_cyc[i] - m_l[i]) / BD;
        b  = 8'(m_byte[i]);
        if (bn == 0) return 1'b0;
        if (bn <= 8) return b[bn-1];
        return 1'b1;
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else for (int i = 0; i < 2; i++) model_step(i);
        end
    end

    // Captured DUT outputs and model expectations, indexed by edges since release.
    bit c_tx   [0:1][0:MAXC-1];
    bit c_busy [0:1][0:MAXC-1];
    bit c_ena  [0:1][0:MAXC-1];
    bit e_tx   [0:1][0:MAXC-1];
    bit e_busy [0:1][0:MAXC-1];
    bit e_ena  [0:1][0:MAXC-1];

    int dec_byte  [$];
    int dec_start [$];
    bit dec_stop  [$];

    task automatic capture(input int n);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            c_tx[0][k] = tx_a; c_busy[0][k] = busy_a; c_ena[0][k] = ena_a;
            c_tx[1][k] = tx_b; c_busy[1][k] = busy_b; c_ena[1][k] = ena_b;
            for (int i = 0; i < 2; i++) begin
                e_tx[i][k] = exp_tx(i); e_busy[i][k] = exp_busy(i); e_ena[i][k] = exp_ena(i);
            end
        end
    endtask

    task automatic decode(input int i, input int n);
        int k;
        logic [7:0] b;
        dec_byte.delete(); dec_start.delete(); dec_stop.delete();
        k = 1;
        while (k + 10 * BD <= n) begin
            if (c_tx[i][k] == 1'b0) begin
                for (int bi = 0; bi < 8; bi++) b[bi] = c_tx[i][k + BD * (bi + 1) + BD / 2];
                dec_byte.push_back(int'(b));
                dec_start.push_back(k);
                dec_stop.push_back(c_tx[i][k + 9 * BD + BD / 2]);
                k += 10 * BD;
            end else begin
                k++;
            end
        end
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2 + $urandom_range(0, 3)) @(negedge clk);
    endtask

    task automatic test_reset();
        int hold;
        rst  = 1'b0;
        hold = 5 + $urandom_range(0, 3);
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            checks += 6;
            if (tx_a !== 1'b1 || tx_b !== 1'b1) begin
                errors++; $display("FAIL reset_txd cycle %0d: got %b/%b want 1", c, tx_a, tx_b);
            end
            if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
                errors++; $display("FAIL reset_busy cycle %0d: got %b/%b want 0", c, busy_a, busy_b);
            end
            if (ena_a !== 1'b0 || ena_b !== 1'b0) begin
                errors++; $display("FAIL reset_ena2 cycle %0d: got %b/%b want 0", c, ena_a, ena_b);
            end
        end
    endtask

    task automatic test_frames();
        int n, first_ena, first_fall, blen, nena;
        n = 365;
        release_rst();
        capture(n);
        first_ena = -1; first_fall = -1; nena = 0;
        for (int k = 1; k <= n; k++) begin
            checks++;
            if (c_tx[0][k] !== e_tx[0][k] || c_busy[0][k] !== e_busy[0][k]
                || c_ena[0][k] !== e_ena[0][k]) begin
                errors++;
                $display("FAIL frames_cycle %0d: txd/busy/ena2 got %b%b%b want %b%b%b", k,
                         c_tx[0][k], c_busy[0][k], c_ena[0][k], e_tx[0][k], e_busy[0][k],
                         e_ena[0][k]);
            end
            if (c_ena[0][k]) nena++;
            if (c_ena[0][k] && first_ena < 0) first_ena = k;
            if (!c_tx[0][k] && first_fall < 0) first_fall = k;
        end
        checks++;
        if (first_ena != 63) begin
            errors++; $display("FAIL first_ena2: got cycle %0d want 63", first_ena);
        end
        checks++;
        if (nena != 5) begin
            errors++; $display("FAIL ena2_count: got %0d want 5", nena);
        end
        checks++;
        if (first_fall != 64) begin
            errors++; $display("FAIL first_start_bit: got cycle %0d want 64", first_fall);
        end
        blen = 0;
        for (int k = 64; k <= n && c_busy[0][k]; k++) blen++;
        checks++;
        if (blen != 40) begin
            errors++; $display("FAIL busy_length: got %0d want 40", blen);
        end
        decode(0, n);
        checks++;
        if (dec_byte.size() != 5) begin
            errors++; $display("FAIL frame_count: got %0d want 5", dec_byte.size());
        end
        for (int j = 0; j < dec_byte.size(); j++) begin
            checks += 2;
            if (dec_byte[j] != j) begin
                errors++; $display("FAIL frame_byte %0d: got %02h want %02h", j, dec_byte[j], j);
            end
            if (!dec_stop[j]) begin
                errors++; $display("FAIL stop_bit %0d: got 0 want 1", j);
            end
        end
    endtask

    task automatic test_overrun_wrap();
        int n;
        n = 301;
        apply_reset();
        release_rst();
        capture(n);
        for (int k = 1; k <= n; k++) begin
            checks++;
            if (c_tx[1][k] !== e_tx[1][k] || c_busy[1][k] !== e_busy[1][k]
                || c_ena[1][k] !== e_ena[1][k]) begin
                errors++;
                $display("FAIL overrun_cycle %0d: txd/busy/ena2 got %b%b%b want %b%b%b", k,
                         c_tx[1][k], c_busy[1][k], c_ena[1][k], e_tx[1][k], e_busy[1][k],
                         e_ena[1][k]);
            end
            if (k >= 16) begin
                checks++;
                if (c_busy[1][k] !== 1'b1) begin
                    errors++; $display("FAIL busy_gap cycle %0d: got %b want 1", k, c_busy[1][k]);
                end
            end
        end
        decode(1, n);
        checks++;
        if (dec_byte.size() != 7) begin
            errors++; $display("FAIL overrun_frames: got %0d want 7", dec_byte.size());
        end
        for (int j = 0; j < dec_byte.size(); j++) begin
            checks += 2;
            if (dec_byte[j] != j % 4) begin
                errors++; $display("FAIL wrap_byte %0d: got %02h want %02h", j, dec_byte[j], j % 4);
            end
            if (dec_start[j] != 16 + 40 * j) begin
                errors++;
                $display("FAIL b2b_start %0d: got cycle %0d want %0d", j, dec_start[j], 16 + 40 * j);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int r, n, first_fall;
        r = $urandom_range(0, BD - 1);
        apply_reset();
        release_rst();
        capture(64 + 4 * BD + r);
        // Data bit 3 of byte 0x00 is on the line.
        checks += 2;
        if (c_tx[0][64 + 4 * BD + r] !== 1'b0) begin
            errors++; $display("FAIL pre_reset_bit3: got %b want 0", c_tx[0][64 + 4 * BD + r]);
        end
        if (c_busy[0][64 + 4 * BD + r] !== 1'b1) begin
            errors++; $display("FAIL pre_reset_busy: got %b want 1", c_busy[0][64 + 4 * BD + r]);
        end
        #2 rst = 1'b0;
        #1;
        checks += 2;
        if (tx_a !== 1'b1) begin
            errors++; $display("FAIL async_reset_txd: got %b want 1", tx_a);
        end
        if (busy_a !== 1'b0) begin
            errors++; $display("FAIL async_reset_busy: got %b want 0", busy_a);
        end
        repeat (3) @(negedge clk);
        release_rst();
        n = 64 + 45;
        capture(n);
        first_fall = -1;
        for (int k = 1; k <= n; k++) begin
            checks++;
            if (c_tx[0][k] !== e_tx[0][k] || c_busy[0][k] !== e_busy[0][k]) begin
                errors++;
                $display("FAIL post_reset_cycle %0d: txd/busy got %b%b want %b%b", k,
                         c_tx[0][k], c_busy[0][k], e_tx[0][k], e_busy[0][k]);
            end
            if (!c_tx[0][k] && first_fall < 0) first_fall = k;
        end
        checks++;
        if (first_fall != 64) begin
            errors++; $display("FAIL post_reset_start: got cycle %0d want 64", first_fall);
        end
        decode(0, n);
        checks++;
        if (dec_byte.size() < 1 || dec_byte[0] != 0) begin
            errors++;
            $display("FAIL post_reset_byte: got %0d frames first %0d want 0x00", dec_byte.size(),
                     (dec_byte.size() > 0) ? dec_byte[0] : -1);
        end
    endtask

    initial begin
        rst = 1'b0;
        test_reset();
        test_frames();
        test_overrun_wrap();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
